pwm_gen: RTL
============

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, which is the width of the consumed counter value.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port count, input, WIDTH bits, the free-running upcounter value (0 .. 2^WIDTH-1, wraps to 0).
REQ-005 SHALL have port enable, input, 1 bit, the PWM run request (level).
REQ-006 SHALL have port duty_data, input, WIDTH+1 bits, the requested high-time in count ticks.
REQ-007 SHALL have port duty_valid, input, 1 bit, which qualifies duty_data.
REQ-008 SHALL have port duty_ready, output, 1 bit; the block can accept duty_data when it is high.
REQ-009 SHALL have port pwm_out, output, 1 bit, the registered PWM waveform.
REQ-010 SHALL have port period_done, output, 1 bit, a registered one-cycle pulse per completed counter period.

Function
REQ-011 SHALL define "boundary" as the cycle in which count == {WIDTH{1'b1}}; the next period starts when count == 0.
REQ-012 SHALL hold an active duty register (duty_act, WIDTH+1 bits), a pending register (duty_pend) and a pending flag (pend).
REQ-013 SHALL drive duty_ready = ~pend & ~rst (combinational).
REQ-014 SHALL treat a handshake as complete when duty_valid & duty_ready are both high at a rising edge; duty_data is then captured into duty_pend and pend is set.
REQ-015 SHALL, on a boundary edge with pend=1, copy duty_pend into duty_act and clear pend.
REQ-016 SHALL, when a handshake and a boundary fall on the same edge with pend=0, load duty_data directly into duty_act and leave pend at 0.
REQ-017 SHALL never change duty_act except on a boundary edge, so there is no mid-period glitch.
REQ-018 SHALL hold duty_valid/duty_data stable while duty_ready=0; the block ignores them in that state.
REQ-019 SHALL clamp duty_act values >= 2^WIDTH to 2^WIDTH, which means pwm_out is high for the entire period (100%); duty 0 means always low.
REQ-020 SHALL implement a run state machine with states IDLE, ARMED and RUN.
REQ-021 SHALL implement these FSM transitions: IDLE->ARMED when enable=1; ARMED->RUN on a boundary edge with enable=1; ARMED->IDLE when enable=0; RUN->IDLE when enable=0 (immediate, not period-aligned).
REQ-022 SHALL ensure a RUN period always starts at count == 0, with no partial first period.
REQ-023 SHALL compute pwm_out(t+1) = (state(t)==RUN) & ({1'b0,count(t)} < duty_act(t)), with a compare width of WIDTH+1 bits and one-cycle latency.
REQ-024 SHALL compute period_done(t+1) = (state(t)==RUN) & boundary(t), which is independent of the duty value.
REQ-025 SHALL tolerate a count discontinuity (upstream reset): the compare uses whatever count value is present, and the boundary is detected only from the value.
REQ-026 SHALL NOT require the duty handshake to depend on state; duty updates are accepted in IDLE, ARMED and RUN alike.

Reset
REQ-027 SHALL, while rst=1 at an edge, set state=IDLE, duty_act=0, duty_pend=0, pend=0, pwm_out=0 and period_done=0.
REQ-028 SHALL hold duty_ready=0 while rst=1 and set it to 1 in the first cycle after rst deasserts.
REQ-029 SHALL, when reset is asserted mid-period in RUN, drop pwm_out to 0 on the next edge and discard any pending duty.

Verification
REQ-030 SHALL cover, with WIDTH=4, duty 5 loaded, then enable: pwm_out high for exactly 5 of every 16 cycles, rising one cycle after count==0, and period_done pulsing one cycle after count==15.
REQ-031 SHALL cover duty 16 and duty 31: pwm_out continuously high across periods (clamp); duty 0: pwm_out never high.
REQ-032 SHALL cover a handshake of duty 12 mid-period while running at 4: the current period stays at 4 high cycles, the next period has 12; duty_ready is low from the handshake edge until the boundary edge.
REQ-033 SHALL cover duty_valid held with duty 9 on the edge where count==15 and pend=0: the immediately following period has 9 high cycles and duty_ready stays 1.
REQ-034 SHALL cover enable asserted at count==7: no pwm_out activity until count wraps to 0 (ARMED), then a full period; enable deasserted at count==2 in RUN: pwm_out is 0 on the next cycle and period_done is not asserted for that period.
REQ-035 SHALL cover rst pulsed for one cycle while running duty 10 with a pending 3: all outputs zero, duty_ready 0 during rst then 1, and re-enable yields duty 0 (no high cycles).

Source files
------------

// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//
// Purpose: turns an externally supplied free-running counter into a PWM
// waveform. The duty value arrives over a valid/ready handshake. It is only
// applied at a period boundary, so a period is never cut short or stretched
// partway through. A small run state machine makes sure the output always
// starts on a whole period.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   count        free-running up-counter value (0 .. 2^WIDTH-1, wraps to 0)
//   enable       run request (level)
//   duty_data    requested high time in count ticks (WIDTH+1 bits)
//   duty_valid   qualifies duty_data
//   duty_ready   high when a new duty value can be accepted
//   pwm_out      registered PWM waveform
//   period_done  registered one-cycle pulse per completed period while running
// ---------------------------------------------------------------------------
module pwm_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic [WIDTH:0]   duty_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } run_state_t;

  // Any duty of 2^WIDTH or more means the output is high for the whole period.
  localparam logic [WIDTH:0] DUTY_FULL = {1'b1, {WIDTH{1'b0}}};

  run_state_t     state;
  run_state_t     state_next;
  logic [WIDTH:0] duty_act;
  logic [WIDTH:0] duty_pend;
  logic           pend;
  logic           boundary;
  logic           handshake;

  function automatic logic [WIDTH:0] clamp_duty(input logic [WIDTH:0] value);
    clamp_duty = (value > DUTY_FULL) ? DUTY_FULL : value;
  endfunction

  // The boundary is taken only from the count value itself. A jump in the
  // counter, for example after an upstream reset, therefore needs no special
  // handling.
  assign boundary   = (count == {WIDTH{1'b1}});
  assign duty_ready = ~pend & ~rst;
  assign handshake  = duty_valid & duty_ready;

  // Duty registers. duty_act changes only on a boundary edge. A value taken
  // in on that same edge with nothing pending goes straight to duty_act, so
  // it is used from the very next period without spending a cycle in
  // duty_pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_act  <= '0;
      duty_pend <= '0;
      pend      <= 1'b0;
    end else if (boundary) begin
      if (pend) begin
        duty_act <= clamp_duty(duty_pend);
        pend     <= 1'b0;
      end else if (handshake) begin
        duty_act <= clamp_duty(duty_data);
      end
    end else if (handshake) begin
      duty_pend <= duty_data;
      pend      <= 1'b1;
    end
  end

  // Run state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leaving RUN happens at once when enable drops. Entering RUN waits for a
  // boundary, so the first period in RUN begins at count == 0.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = ARMED;
      ARMED:   if (!enable) state_next = IDLE;
               else if (boundary) state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, one cycle behind the count value they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= (state == RUN) && ({1'b0, count} < duty_act);
      period_done <= (state == RUN) && boundary;
    end
  end

endmodule
